// File: rtl/stream_mux.sv
// Registered N-way stream multiplexer with valid/ready handshakes, explicit-select or round-robin grant.
// Optional packet locking is compiled in with `define MUX_LOCK_EN.
module stream_mux #(
  parameter int BITS  = 64,
  parameter int WORDS = 2,
  parameter int MODE  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BITS-1:0]          in [0:WORDS-1],
  input  logic [WORDS-1:0]         in_valid,
  output logic [WORDS-1:0]         in_ready,
  input  logic [WORDS-1:0]         in_last,
  input  logic [$clog2(WORDS)-1:0] sel,
  output logic [BITS-1:0]          out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WORDS)-1:0] out_src,
  output logic                     out_last
);

  localparam int SW = $clog2(WORDS);

  logic           load;
  logic           xfer;
  logic [WORDS-1:0] grant;
  logic [SW-1:0]  idx;
  logic [SW-1:0]  rr;
  logic           locked;
  logic [SW-1:0]  lock_ch;
  logic           advance;

  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
    if (int'(i) == WORDS - 1) return '0;
    else return SW'(i + 1'b1);
  endfunction

  assign load     = !out_valid || out_ready;
  assign xfer     = (|grant) && load;
  assign in_ready = grant & {WORDS{load}};

  // grant selection: lock overrides, otherwise select or rotating priority
  always_comb begin
    int  pos;
    logic found;
    grant = '0;
    pos   = 0;
    found = 1'b0;
    if (locked) begin
      grant[lock_ch] = in_valid[lock_ch];
    end else if (MODE == 0) begin
      if (int'(sel) < WORDS) grant[sel] = in_valid[sel];
      else grant = '0;
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        pos        = (int'(rr) + k) % WORDS;
        grant[pos] = in_valid[pos] && !found;
        found      = found || in_valid[pos];
      end
    end
  end

  // one-hot grant to channel index
  always_comb begin
    idx = '0;
    for (int i = 0; i < WORDS; i++) begin
      idx = idx | (grant[i] ? SW'(i) : '0);
    end
  end

`ifdef MUX_LOCK_EN
  assign advance = in_last[idx];

  // packet lock: held from a non-last beat until the last beat transfers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      locked  <= !in_last[idx];
      lock_ch <= idx;
    end
  end
`else
  assign advance = 1'b1;
  assign locked  = 1'b0;
  assign lock_ch = '0;
`endif

  // output register stage and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      out_last  <= 1'b0;
      rr        <= '0;
    end else if (load) begin
      if (xfer) begin
        out       <= in[idx];
        out_src   <= idx;
        out_last  <= in_last[idx];
        out_valid <= 1'b1;
        if (MODE == 1 && advance) rr <= next_idx(idx);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a round-robin 4-way instance and an explicit-select 3-way instance.
module tb_stream_mux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] r_in [0:3];
  logic [3:0]  r_valid, r_ready, r_last;
  logic [1:0]  r_sel, r_src;
  logic [63:0] r_out;
  logic        r_ov, r_oready, r_olast;

  logic [63:0] s_in [0:2];
  logic [2:0]  s_valid, s_ready, s_last;
  logic [1:0]  s_sel, s_src;
  logic [63:0] s_out;
  logic        s_ov, s_oready, s_olast;

  int checks = 0;
  int errors = 0;

  stream_mux #(.BITS(64), .WORDS(4), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .in(r_in), .in_valid(r_valid), .in_ready(r_ready),
    .in_last(r_last), .sel(r_sel), .out(r_out), .out_valid(r_ov), .out_ready(r_oready),
    .out_src(r_src), .out_last(r_olast)
  );

  stream_mux #(.BITS(64), .WORDS(3), .MODE(0)) u_sel (
    .clk(clk), .reset(reset), .in(s_in), .in_valid(s_valid), .in_ready(s_ready),
    .in_last(s_last), .sel(s_sel), .out(s_out), .out_valid(s_ov), .out_ready(s_oready),
    .out_src(s_src), .out_last(s_olast)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  int exp_src [0:3];
  int exp_last [0:3];
  int ch0_cnt;

  initial begin
    r_valid = 4'd0; r_last = 4'd0; r_sel = 2'd0; r_oready = 1'b1;
    s_valid = 3'd0; s_last = 3'd0; s_sel = 2'd0; s_oready = 1'b1;
    for (int i = 0; i < 4; i++) r_in[i] = 64'h1000 + 64'(i);
    s_in[0] = 64'h1111; s_in[1] = 64'hA5A5; s_in[2] = 64'h2222;

    #1;
    check("rst_r_ov", {63'd0, r_ov}, 64'd0);
    check("rst_r_out", r_out, 64'd0);
    check("rst_r_src", {62'd0, r_src}, 64'd0);
    check("rst_r_last", {63'd0, r_olast}, 64'd0);
    check("rst_s_ov", {63'd0, s_ov}, 64'd0);
    check("rst_s_out", s_out, 64'd0);

    @(negedge clk);
    reset = 1'b0;

    // all four channels valid: strict rotation 0,1,2,3,0,1,2,3
    r_valid = 4'hF;
    #1 check("rr_ready_first", {60'd0, r_ready}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_src", {62'd0, r_src}, 64'(i % 4));
      check("rr_ov", {63'd0, r_ov}, 64'd1);
      check("rr_out", r_out, 64'h1000 + 64'(i % 4));
      #1 check("rr_ready_onehot", {60'd0, r_ready}, 64'(1 << ((i + 1) % 4)));
    end
    @(negedge clk);
    check("rr_ninth_src", {62'd0, r_src}, 64'd0);

    // asynchronous reset while a beat is held (rr is 1 at this point)
    #2 reset = 1'b1;
    #1;
    check("midrst_ov", {63'd0, r_ov}, 64'd0);
    check("midrst_out", r_out, 64'd0);
    check("midrst_src", {62'd0, r_src}, 64'd0);
    check("midrst_rr", {60'd0, r_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 check("postrst_ready", {60'd0, r_ready}, 64'd1);
    @(negedge clk);
    check("postrst_src", {62'd0, r_src}, 64'd0);
    check("postrst_ov", {63'd0, r_ov}, 64'd1);

    // move rr to 2 via a channel-1 transfer, then idle, then channels 1 and 3
    r_valid = 4'b0010;
    #1 check("sparse_ready_ch1", {60'd0, r_ready}, 64'h2);
    @(negedge clk);
    check("sparse_src1", {62'd0, r_src}, 64'd1);
    r_valid = 4'b0000;
    #1 check("idle_ready", {60'd0, r_ready}, 64'd0);
    @(negedge clk);
    check("idle_ov", {63'd0, r_ov}, 64'd0);
    @(negedge clk);
    check("idle_ov2", {63'd0, r_ov}, 64'd0);
    r_valid = 4'b1010;
    #1 check("sparse_grant3", {60'd0, r_ready}, 64'h8);
    @(negedge clk);
    check("sparse_src3", {62'd0, r_src}, 64'd3);
    #1 check("sparse_grant1", {60'd0, r_ready}, 64'h2);
    @(negedge clk);
    check("sparse_src1b", {62'd0, r_src}, 64'd1);
    #1 check("sparse_grant3b", {60'd0, r_ready}, 64'h8);
    @(negedge clk);
    check("sparse_src3b", {62'd0, r_src}, 64'd3);

    // channel 0 sends a 3-beat packet while channel 1 stays valid (rr is 0 now)
`ifdef MUX_LOCK_EN
    exp_src  = '{0, 0, 0, 1};
    exp_last = '{0, 0, 1, 0};
`else
    exp_src  = '{0, 1, 0, 1};
    exp_last = '{0, 0, 0, 0};
`endif
    ch0_cnt = 0;
    r_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      r_last = {3'b000, (ch0_cnt == 2)};
      #1 check("pkt_ready", {60'd0, r_ready}, 64'(1 << exp_src[k]));
      if (exp_src[k] == 0) ch0_cnt++;
      @(negedge clk);
      check("pkt_src", {62'd0, r_src}, 64'(exp_src[k]));
      check("pkt_last", {63'd0, r_olast}, 64'(exp_last[k]));
    end
    r_valid = 4'b0000;
    r_last  = 4'b0000;

    // explicit select with backpressure
    s_valid = 3'b111;
    s_sel   = 2'd1;
    #1 check("sel_ready", {61'd0, s_ready}, 64'h2);
    @(negedge clk);
    check("bp_out0", s_out, 64'hA5A5);
    check("bp_src0", {62'd0, s_src}, 64'd1);
    s_oready = 1'b0;
    s_in[1]  = 64'h5A5A;
    s_sel    = 2'd2;
    #1 check("bp_ready0", {61'd0, s_ready}, 64'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_hold_out", s_out, 64'hA5A5);
      check("bp_hold_ov", {63'd0, s_ov}, 64'd1);
      check("bp_hold_src", {62'd0, s_src}, 64'd1);
      check("bp_hold_ready", {61'd0, s_ready}, 64'd0);
    end
    s_sel    = 2'd1;
    s_oready = 1'b1;
    #1 check("bp_release_ready", {61'd0, s_ready}, 64'h2);
    @(negedge clk);
    check("bp_next_out", s_out, 64'h5A5A);
    check("bp_next_ov", {63'd0, s_ov}, 64'd1);

    // out-of-range select: no grant, pending beat drains
    s_sel = 2'd3;
    #1 check("oor_ready", {61'd0, s_ready}, 64'd0);
    @(negedge clk);
    check("oor_ov", {63'd0, s_ov}, 64'd0);
    check("oor_ready2", {61'd0, s_ready}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
